// File: rtl/rx_packet_fifo.sv
// rx_packet_fifo: store-and-forward receive buffer that sits behind a MAC.
// Frames are written speculatively and made visible to the read side only
// once their last beat arrives good. Bad frames (tuser on tlast) and frames
// that do not fit are rolled back and counted. The read side is a single
// registered stage fed by a synchronous memory read.
module rx_packet_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s00_axis_tkeep,
  input  logic                    s00_axis_tvalid,
  input  logic                    s00_axis_tlast,
  input  logic                    s00_axis_tuser,
  output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m00_axis_tkeep,
  output logic                    m00_axis_tvalid,
  output logic                    m00_axis_tlast,
  input  logic                    m00_axis_tready,
  output logic                    o_drop_error,
  output logic                    o_drop_overflow,
  output logic [15:0]             o_drop_count
);

  localparam int DATA_NBYTES = DATA_WIDTH / 8;
  localparam int WORD_W      = DATA_WIDTH + DATA_NBYTES + 1;
  localparam logic [DEPTH_LOG2:0] FULL_FILL = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic {
    WR_ACCEPT,
    WR_DISCARD
  } wr_state_e;

  // Buffer storage: {tlast, tkeep, tdata}
  logic [WORD_W-1:0] mem_q [2**DEPTH_LOG2];

  wr_state_e           state_q, state_d;
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] wr_commit_q, wr_commit_d;
  logic [DEPTH_LOG2:0] rd_ptr_q;
  logic [DEPTH_LOG2:0] fill;
  logic                full;
  logic                wr_en;
  logic                drop_err_q, drop_err_d;
  logic                drop_ovf_q, drop_ovf_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;

  logic                rd_avail;
  logic                rd_en;
  logic [WORD_W-1:0]   out_word_q;
  logic                out_valid_q, out_valid_d;

  // Fill is judged against the read pointer at the start of the cycle, so a
  // word leaving in the same cycle does not make room for an incoming beat.
  assign fill = wr_ptr_q - rd_ptr_q;
  assign full = (fill == FULL_FILL);

  // Write FSM state register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= WR_ACCEPT;
    end else begin
      state_q <= state_d;
    end
  end

  // Write FSM next-state: a non-final beat hitting a full buffer sends the
  // rest of that frame to the discard state until its tlast.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WR_ACCEPT: begin
        if (s00_axis_tvalid && full && !s00_axis_tlast) begin
          state_d = WR_DISCARD;
        end
      end
      WR_DISCARD: begin
        if (s00_axis_tvalid && s00_axis_tlast) begin
          state_d = WR_ACCEPT;
        end
      end
      default: state_d = WR_ACCEPT;
    endcase
  end

  // Write FSM outputs: memory write, pointer advance/commit/rewind, drop pulses
  always_comb begin
    wr_en       = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    drop_err_d  = 1'b0;
    drop_ovf_d  = 1'b0;
    case (state_q)
      WR_ACCEPT: begin
        if (s00_axis_tvalid) begin
          if (!full) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (s00_axis_tlast) begin
              if (s00_axis_tuser) begin
                wr_ptr_d   = wr_commit_q;
                drop_err_d = 1'b1;
              end else begin
                wr_commit_d = wr_ptr_q + 1'b1;
              end
            end
          end else begin
            wr_ptr_d = wr_commit_q;
            if (s00_axis_tlast) begin
              drop_ovf_d = 1'b1;
            end
          end
        end
      end
      WR_DISCARD: begin
        if (s00_axis_tvalid && s00_axis_tlast) begin
          drop_ovf_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Saturating count of every discarded frame
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if ((drop_err_d || drop_ovf_d) && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Write-side registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      drop_err_q  <= 1'b0;
      drop_ovf_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      drop_err_q  <= drop_err_d;
      drop_ovf_q  <= drop_ovf_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Buffer write port; contents need no reset since pointers gate all reads
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= {s00_axis_tlast, s00_axis_tkeep, s00_axis_tdata};
    end
  end

  // The output register doubles as the synchronous read register: it loads
  // whenever committed data exists and the register is empty or draining,
  // which gives one word per cycle across frame boundaries and holds still
  // while stalled.
  assign rd_avail = (rd_ptr_q != wr_commit_q);
  assign rd_en    = rd_avail && (!out_valid_q || m00_axis_tready);

  // Output valid next-state
  always_comb begin
    out_valid_d = out_valid_q;
    if (rd_en) begin
      out_valid_d = 1'b1;
    end else if (m00_axis_tready) begin
      out_valid_d = 1'b0;
    end
  end

  // Read-side registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr_q    <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (rd_en) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        out_word_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
      end
    end
  end

  assign m00_axis_tdata  = out_word_q[DATA_WIDTH-1:0];
  assign m00_axis_tkeep  = out_word_q[DATA_WIDTH +: DATA_NBYTES];
  assign m00_axis_tlast  = out_word_q[WORD_W-1];
  assign m00_axis_tvalid = out_valid_q;
  assign o_drop_error    = drop_err_q;
  assign o_drop_overflow = drop_ovf_q;
  assign o_drop_count    = drop_cnt_q;

endmodule
